pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Central stall/flush controller for the 5-stage pipeline. Produces the stall that holds PC and IF/ID
// and bubbles ID/EX, and the flush that clears IF/ID, ID/EX and EX/MEM on exception, interrupt or eret.
// Also sequences the multi-cycle mult/div unit through a busy counter, and keeps saturating stall and
// flush statistics counters.
// PARAMETERS
// MULT_CYC  5   busy cycles after a mult/multu issues in EX
// DIV_CYC   10  busy cycles after a div/divu issues in EX
// CNT_W     4   md counter width; must hold max(MULT_CYC,DIV_CYC)
// PORTS
// clk           in   1   clock, rising edge
// reset         in   1   asynchronous, active-low reset (0 = reset)
// d_rs_addr     in   5   rs of instr in ID
// d_rt_addr     in   5   rt of instr in ID
// d_tuse_rs     in   2   cycles until ID instr needs rs; 3 = rs unused
// d_tuse_rt     in   2   cycles until ID instr needs rt; 3 = rt unused
// d_is_md       in   1   ID instr is mult/div/mfhi/mflo/mthi/mtlo
// e_wa          in   5   dest reg of EX instr (0 = none)
// e_tnew        in   2   cycles until EX result is forwardable
// m_wa          in   5   dest reg of MEM instr (0 = none)
// m_tnew        in   2   cycles until MEM result is forwardable
// e_start_mult  in   1   mult/multu in EX this cycle
// e_start_div   in   1   div/divu in EX this cycle
// irq_req       in   1   CP0 exception/interrupt taken, instr in MEM
// eret_m        in   1   eret in MEM
// stall         out  1   hold PC/IF_ID, bubble ID_EX
// flush         out  1   clear IF_ID, ID_EX, EX_MEM
// md_busy       out  1   mult/div unit busy (md_cnt != 0)
// stall_cycles  out  32  saturating count of cycles with stall=1
// flush_count   out  16  saturating count of cycles with flush=1
// BEHAVIOUR
// - Reset (reset=0, async): md_cnt=0, stall_cycles=0, flush_count=0. Hence md_busy=0. stall/flush are
//   combinational from inputs and ignore reset.
// - flush = irq_req | eret_m, same cycle, no latency.
// - Data hazard, zero latency. For port X in {rs,rt}, hzX = (d_X_addr!=0) &&
//   ((d_X_addr==e_wa && d_tuse_X<e_tnew) || (d_X_addr==m_wa && d_tuse_X<m_tnew)).
// - tuse=3 never stalls. Register 0 never stalls.
// - MD hazard: hz_md = d_is_md && (md_busy || e_start_mult || e_start_div).
// - stall = (hz_rs | hz_rt | hz_md) & ~flush. Flush has priority; stall is never 1 while flush=1.
// - md counter, per rising edge:
//   - flush=1: starts in that cycle are ignored because the EX instr is killed; a running count keeps
//     decrementing.
//   - else e_start_div: load DIV_CYC.
//   - else e_start_mult: load MULT_CYC.
//   - else md_cnt!=0: decrement.
//   - A start while md_busy=1 reloads the counter; no queueing.
//   - Both starts together: div wins.
//   - Result: md_busy is high for exactly N cycles following the start cycle.
// - stall_cycles increments on each edge with stall=1 and holds at 32'hFFFFFFFF.
// - flush_count increments on each edge with flush=1 and holds at 16'hFFFF.
// - Reset asserted mid-count: md_cnt clears immediately. A stall held by md then releases in the same
//   cycle, since md_busy=0 and no start is asserted.
// TESTING
// 1. rs=5, tuse_rs=0, e_wa=5, e_tnew=2 -> stall=1. Raise tuse_rs to 2 -> stall=0.
//    Repeat with rs=0 -> stall=0.
// 2. m_wa=7, m_tnew=1, rt=7, tuse_rt=0 -> stall=1. Same with tuse_rt=3 -> stall=0.
// 3. e_start_mult pulse at cycle 0, d_is_md=1 held -> stall=1 in cycles 0..5 and 0 at cycle 6.
//    md_busy=1 in cycles 1..5.
// 4. e_start_div and irq_req both high in one cycle -> flush=1, stall=0, md_busy stays 0 next cycle.
//    Then eret_m pulse -> flush=1 and flush_count=2.
// 5. Drop reset mid-div when md_cnt=6 -> md_busy=0 immediately, counters=0, and the stall releases.
// 6. Hold stall for 2^32+3 cycles (force counter near max) -> stall_cycles saturates at FFFFFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: data and mult/div hazard detection,
// mult/div busy sequencing, and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_start_mult,
  input  logic        e_start_div,
  input  logic        irq_req,
  input  logic        eret_m,
  output logic        stall,
  output logic        flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] md_cnt;
  logic             hz_rs;
  logic             hz_rt;
  logic             hz_md;
  logic             md_start;

  // A tuse of 3 can never be below any 2-bit tnew, so unused operands drop out naturally.
  always_comb begin
    hz_rs = (d_rs_addr != 5'd0) &&
            (((d_rs_addr == e_wa) && (d_tuse_rs < e_tnew)) ||
             ((d_rs_addr == m_wa) && (d_tuse_rs < m_tnew)));
    hz_rt = (d_rt_addr != 5'd0) &&
            (((d_rt_addr == e_wa) && (d_tuse_rt < e_tnew)) ||
             ((d_rt_addr == m_wa) && (d_tuse_rt < m_tnew)));
  end

  assign md_busy  = (md_cnt != '0);
  assign md_start = e_start_mult | e_start_div;
  assign hz_md    = d_is_md & (md_busy | md_start);
  assign flush    = irq_req | eret_m;
  assign stall    = (hz_rs | hz_rt | hz_md) & ~flush;

  // A flushed EX instruction never really issued, so its start is dropped while a running count continues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (!flush && e_start_div) begin
      md_cnt <= DIV_LOAD;
    end else if (!flush && e_start_mult) begin
      md_cnt <= MULT_LOAD;
    end else if (md_busy) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, e_wa, m_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_start_mult, e_start_div, irq_req, eret_m;
  logic        stall, flush, md_busy;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_start_mult(e_start_mult), .e_start_div(e_start_div),
    .irq_req(irq_req), .eret_m(eret_m),
    .stall(stall), .flush(flush), .md_busy(md_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
    e_start_mult = 1'b0; e_start_div = 1'b0; irq_req = 1'b0; eret_m = 1'b0;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    applyStimulus();
    reset = 1'b0;
    #12;
    checkOutput("reset_md_busy", 32'(md_busy), 32'd0);
    checkOutput("reset_stall_cycles", stall_cycles, 32'd0);
    checkOutput("reset_flush_count", 32'(flush_count), 32'd0);
    reset = 1'b1;
    tick();

    // Data hazard on rs against EX
    d_rs_addr = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd2;
    #1 checkOutput("rs_ex_hazard", 32'(stall), 32'd1);
    d_tuse_rs = 2'd2;
    #1 checkOutput("rs_tuse_eq_tnew", 32'(stall), 32'd0);
    d_tuse_rs = 2'd0; d_rs_addr = 5'd0; e_wa = 5'd0;
    #1 checkOutput("rs_reg0", 32'(stall), 32'd0);
    applyStimulus();

    // Data hazard on rt against MEM
    m_wa = 5'd7; m_tnew = 2'd1; d_rt_addr = 5'd7; d_tuse_rt = 2'd0;
    #1 checkOutput("rt_mem_hazard", 32'(stall), 32'd1);
    d_tuse_rt = 2'd3;
    #1 checkOutput("rt_unused", 32'(stall), 32'd0);
    applyStimulus();

    // Mult sequence from clean counters
    pulseReset();
    tick();
    d_is_md = 1'b1; e_start_mult = 1'b1;
    #1 checkOutput("mult_c0_stall", 32'(stall), 32'd1);
    checkOutput("mult_c0_busy", 32'(md_busy), 32'd0);
    tick();
    e_start_mult = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checkOutput($sformatf("mult_c%0d_stall", c), 32'(stall), 32'd1);
      checkOutput($sformatf("mult_c%0d_busy", c), 32'(md_busy), 32'd1);
      tick();
    end
    #1 checkOutput("mult_c6_stall", 32'(stall), 32'd0);
    checkOutput("mult_c6_busy", 32'(md_busy), 32'd0);
    checkOutput("mult_stall_cycles", stall_cycles, 32'd6);
    applyStimulus();

    // Div start killed by same-cycle irq, then eret
    d_is_md = 1'b1; e_start_div = 1'b1; irq_req = 1'b1;
    #1 checkOutput("irq_flush", 32'(flush), 32'd1);
    checkOutput("irq_stall_blocked", 32'(stall), 32'd0);
    tick();
    applyStimulus();
    checkOutput("irq_div_dropped", 32'(md_busy), 32'd0);
    eret_m = 1'b1;
    #1 checkOutput("eret_flush", 32'(flush), 32'd1);
    tick();
    eret_m = 1'b0;
    checkOutput("flush_count_2", 32'(flush_count), 32'd2);
    checkOutput("stall_cycles_held", stall_cycles, 32'd6);

    // Div start then async reset when md_cnt is 6
    d_is_md = 1'b1; e_start_div = 1'b1;
    tick();
    e_start_div = 1'b0;
    repeat (4) tick();
    #1 checkOutput("div_busy_pre_reset", 32'(md_busy), 32'd1);
    checkOutput("div_stall_pre_reset", 32'(stall), 32'd1);
    reset = 1'b0;
    #1 checkOutput("div_reset_busy", 32'(md_busy), 32'd0);
    checkOutput("div_reset_stall", 32'(stall), 32'd0);
    checkOutput("div_reset_stall_cycles", stall_cycles, 32'd0);
    checkOutput("div_reset_flush_count", 32'(flush_count), 32'd0);
    reset = 1'b1;
    applyStimulus();
    tick();

    // Flush counter saturation, with a data hazard that flush must mask
    irq_req = 1'b1; d_rs_addr = 5'd3; d_tuse_rs = 2'd0; e_wa = 5'd3; e_tnew = 2'd1;
    #1 checkOutput("flush_masks_stall", 32'(stall), 32'd0);
    repeat (65534) tick();
    checkOutput("flush_count_fffe", 32'(flush_count), 32'h0000_FFFE);
    tick();
    checkOutput("flush_count_ffff", 32'(flush_count), 32'h0000_FFFF);
    repeat (2) tick();
    checkOutput("flush_count_sat", 32'(flush_count), 32'h0000_FFFF);
    checkOutput("flush_no_stall_count", stall_cycles, 32'd0);
    irq_req = 1'b0;

    // Stall counter saturation from a preloaded value
    #1 checkOutput("stall_hold", 32'(stall), 32'd1);
    force dut.stall_cycles = 32'hFFFF_FFFD;
    #1 release dut.stall_cycles;
    tick();
    checkOutput("stall_cycles_fffe", stall_cycles, 32'hFFFF_FFFE);
    tick();
    checkOutput("stall_cycles_ffff", stall_cycles, 32'hFFFF_FFFF);
    repeat (3) tick();
    checkOutput("stall_cycles_sat", stall_cycles, 32'hFFFF_FFFF);
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
